// File: rtl/out_col_accum_collector.sv
// Column output collector: sums pass_count beats per result, saturates to W bits, and queues results in a FIFO.
// Optional OUT_COL_ACCUM_RELU_EN adds relu_en_i, which forces negative results to zero before they enter the FIFO.
module out_col_accum_collector #(
    parameter int I_WIDTH    = 8,
    parameter int F_WIDTH    = 8,
    parameter int ACC_GUARD  = 4,
    parameter int PASS_WIDTH = 8,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       out_reg_shift_rst_i,
    input  logic [I_WIDTH+F_WIDTH-1:0] in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       cfg_ld_i,
    input  logic [PASS_WIDTH-1:0]      pass_count_i,
    input  logic [CNT_WIDTH-1:0]       out_count_i,
    input  logic                       start_i,
`ifdef OUT_COL_ACCUM_RELU_EN
    input  logic                       relu_en_i,
`endif
    output logic [I_WIDTH+F_WIDTH-1:0] out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overflow_o
);
    localparam int W     = I_WIDTH + F_WIDTH;
    localparam int A     = W + ACC_GUARD;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [A-1:0]          acc_q, acc_d;
    logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [PASS_WIDTH-1:0] pass_cfg_q, pass_cfg_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_cfg_q, cnt_cfg_d;
    logic                  relu_q, relu_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [W-1:0]          mem_d [FIFO_DEPTH];

    logic                  fifo_empty, fifo_full;
    logic                  accept, push, pop, last_beat, clamp, relu_in;
    logic [PASS_WIDTH-1:0] last_idx;
    logic [CNT_WIDTH-1:0]  res_cnt_inc;
    logic [A-1:0]          sum;
    logic [W-1:0]          sat_val, push_data;

`ifdef OUT_COL_ACCUM_RELU_EN
    assign relu_in = relu_en_i;
`else
    assign relu_in = 1'b0;
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign in_ready_o  = (state_q == ST_RUN) && !fifo_full;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = !fifo_empty;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
    assign busy_o      = (state_q != ST_IDLE);
    assign overflow_o  = ovf_q;

    assign sum         = acc_q + {{ACC_GUARD{in_data_i[W-1]}}, in_data_i};
    assign clamp       = (sum[A-1:W-1] != '0) && (sum[A-1:W-1] != '1);
    assign sat_val     = !clamp   ? sum[W-1:0] :
                         sum[A-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign push_data   = (relu_q && sat_val[W-1]) ? '0 : sat_val;

    // A pass count of zero behaves like one: every beat completes a result.
    assign last_idx    = (pass_cfg_q == '0) ? '0 : pass_cfg_q - 1'b1;
    assign last_beat   = (pass_cnt_q == last_idx);
    assign push        = accept && last_beat;
    assign res_cnt_inc = res_cnt_q + 1'b1;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            assign mem_d[gi] = (push && (wr_ptr_q[PTR_W-1:0] == PTR_W'(gi))) ? push_data : mem_q[gi];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pass_cnt_d = pass_cnt_q;
        pass_cfg_d = pass_cfg_q;
        res_cnt_d  = res_cnt_q;
        cnt_cfg_d  = cnt_cfg_q;
        relu_d     = relu_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
        done_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_ld_i) begin
                    pass_cfg_d = pass_count_i;
                    cnt_cfg_d  = out_count_i;
                    relu_d     = relu_in;
                end
                // Reads the _d config so a same-cycle load is used by this start.
                if (start_i) begin
                    acc_d      = '0;
                    pass_cnt_d = '0;
                    res_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    state_d    = (cnt_cfg_d == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        acc_d      = '0;
                        pass_cnt_d = '0;
                        res_cnt_d  = res_cnt_inc;
                        if (clamp) begin
                            ovf_d = 1'b1;
                        end
                        if (res_cnt_inc == cnt_cfg_q) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        acc_d      = sum;
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
        if (out_reg_shift_rst_i) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            pass_cnt_q <= '0;
            pass_cfg_q <= '0;
            res_cnt_q  <= '0;
            cnt_cfg_q  <= '0;
            relu_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pass_cnt_q <= pass_cnt_d;
            pass_cfg_q <= pass_cfg_d;
            res_cnt_q  <= res_cnt_d;
            cnt_cfg_q  <= cnt_cfg_d;
            relu_q     <= relu_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_out_col_accum_collector.sv
// Scoreboard bench for out_col_accum_collector: a reference model queues each expected result, and a monitor checks results as they are popped.
module tb_out_col_accum_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        cfg_ld;
    logic [7:0]  pass_count;
    logic [15:0] out_count;
    logic        start;
    logic        relu_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];

    int          m_pass, m_cnt, m_pcnt;
    bit          m_relu, m_ovf;
    longint      m_acc;
    logic [15:0] bp_vals [6];

    always #5 clk = ~clk;

    out_col_accum_collector dut (
        .clk_i               (clk),
        .out_reg_shift_rst_i (rst),
        .in_data_i           (in_data),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .cfg_ld_i            (cfg_ld),
        .pass_count_i        (pass_count),
        .out_count_i         (out_count),
        .start_i             (start),
`ifdef OUT_COL_ACCUM_RELU_EN
        .relu_en_i           (relu_en),
`endif
        .out_data_o          (out_data),
        .out_valid_o         (out_valid),
        .out_ready_i         (out_ready),
        .busy_o              (busy),
        .done_o              (done),
        .overflow_o          (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare every popped result against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("sb_has_entry", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("pop  data=%h expected=%h", out_data, e);
                check_val("out_data", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_out_data"},  32'(out_data),  32'd0);
        check_val({tag, "_busy"},      32'(busy),      32'd0);
        check_val({tag, "_done"},      32'(done),      32'd0);
        check_val({tag, "_overflow"},  32'(overflow),  32'd0);
    endtask

    task automatic run_start(input bit load, input int pass, input int cnt, input bit relu);
        cfg_ld     = load;
        pass_count = pass[7:0];
        out_count  = cnt[15:0];
        relu_en    = relu;
        start      = 1'b1;
        if (load) begin
            m_pass = pass;
            m_cnt  = cnt;
            m_relu = relu;
        end
        m_acc  = 0;
        m_pcnt = 0;
        m_ovf  = 1'b0;
        tick();
        cfg_ld = 1'b0;
        start  = 1'b0;
        $display("start pass=%0d count=%0d load=%0d", m_pass, m_cnt, load);
    endtask

    task automatic send_beat(input logic [15:0] d);
        int     guard;
        int     eff;
        longint v;
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_val("beat_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        $display("beat data=%h", d);
        eff   = (m_pass == 0) ? 1 : m_pass;
        m_acc = m_acc + longint'($signed(d));
        if (m_pcnt == eff - 1) begin
            if (m_acc > 32767) begin
                v     = 32767;
                m_ovf = 1'b1;
            end else if (m_acc < -32768) begin
                v     = -32768;
                m_ovf = 1'b1;
            end else begin
                v = m_acc;
            end
            if (m_relu && v < 0) begin
                v = 0;
            end
            exp_q.push_back(v[15:0]);
            m_acc  = 0;
            m_pcnt = 0;
        end else begin
            m_pcnt++;
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_done_no_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_ld = 1'b0; pass_count = '0;
        out_count = '0; start = 1'b0; relu_en = 1'b0; out_ready = 1'b0;
        m_pass = 0; m_cnt = 0; m_relu = 1'b0; m_acc = 0; m_pcnt = 0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        tick();
        rst = 1'b0;

        // Abort a run with two results held in the FIFO.
        run_start(1'b1, 1, 4, 1'b0);
        check_val("mid_busy", 32'(busy), 32'd1);
        send_beat(16'h1111);
        send_beat(16'h2222);
        @(negedge clk);
        check_val("mid_valid", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        m_pass = 0; m_cnt = 0; m_relu = 1'b0; m_ovf = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        tick();
        rst = 1'b0;

        // Cleared config: out_count is 0, so the run drains immediately.
        run_start(1'b0, 0, 0, 1'b0);
        check_val("cnt0_busy", 32'(busy), 32'd1);
        check_val("cnt0_in_ready", 32'(in_ready), 32'd0);
        wait_done("cnt0");

        // Basic three-pass sum.
        out_ready = 1'b1;
        run_start(1'b1, 3, 1, 1'b0);
        send_beat(16'h0100);
        send_beat(16'h0200);
        send_beat(16'hFF00);
        check_val("lat_valid", 32'(out_valid), 32'd1);
        check_val("lat_data", 32'(out_data), 32'h0200);
        wait_done("basic");
        check_val("basic_ovf", 32'(overflow), 32'd0);

        // Positive then negative saturation; overflow cleared by the next start.
        run_start(1'b1, 2, 1, 1'b0);
        send_beat(16'h7000);
        send_beat(16'h7000);
        check_val("satp_data", 32'(out_data), 32'h7FFF);
        wait_done("satp");
        check_val("satp_ovf", 32'(overflow), 32'd1);
        run_start(1'b0, 0, 0, 1'b0);
        check_val("ovf_cleared", 32'(overflow), 32'd0);
        send_beat(16'h8000);
        send_beat(16'h8000);
        check_val("satn_data", 32'(out_data), 32'h8000);
        wait_done("satn");
        check_val("satn_ovf", 32'(overflow), 32'd1);

        // Back-pressure: the FIFO fills after four results.
        for (int i = 0; i < 6; i++) begin
            bp_vals[i] = 16'($urandom_range(0, 65535));
        end
        out_ready = 1'b0;
        run_start(1'b1, 1, 6, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_beat(bp_vals[i]);
        end
        @(negedge clk);
        check_val("bp_ready_low", 32'(in_ready), 32'd0);
        check_val("bp_valid", 32'(out_valid), 32'd1);
        tick();
        out_ready = 1'b1;
        for (int i = 4; i < 6; i++) begin
            send_beat(bp_vals[i]);
        end
        wait_done("bp");

        // Full FIFO, then concurrent pushes and pops.
        out_ready = 1'b0;
        run_start(1'b1, 1, 8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send_beat(16'h0A00 + 16'(i));
        end
        @(negedge clk);
        check_val("full_ready_low", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(16'hB000 + 16'(i));
        end
        wait_done("full");

        // pass_count of zero acts as one.
        run_start(1'b1, 0, 1, 1'b0);
        send_beat(16'h0003);
        check_val("pass0_data", 32'(out_data), 32'h0003);
        wait_done("pass0");

`ifdef OUT_COL_ACCUM_RELU_EN
        run_start(1'b1, 1, 1, 1'b1);
        send_beat(16'hFFFD);
        check_val("relu_data", 32'(out_data), 32'h0000);
        wait_done("relu");
        check_val("relu_ovf", 32'(overflow), 32'd0);
`else
        run_start(1'b1, 1, 1, 1'b0);
        send_beat(16'hFFFD);
        check_val("neg_data", 32'(out_data), 32'hFFFD);
        wait_done("neg");
`endif

        @(negedge clk);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/out_col_accum_collector.md
Name: out_col_accum_collector

Overview:
- Sits directly downstream of the column output shift register and consumes its aligned per-column output stream (signed Q I_WIDTH.F_WIDTH).
- Accumulates partial sums over a configurable number of passes (input-channel tiles), then saturates each sum back to I_WIDTH+F_WIDTH bits.
- Buffers results in a small FIFO and hands them to the output memory writer over a valid/ready handshake, applying back-pressure upstream.

Parameters:
- I_WIDTH, 8, integer bits of the data word.
- F_WIDTH, 8, fractional bits of the data word; W = I_WIDTH+F_WIDTH.
- ACC_GUARD, 4, extra accumulator MSBs; accumulator width A = W+ACC_GUARD.
- PASS_WIDTH, 8, width of the pass-count configuration.
- CNT_WIDTH, 16, width of the result-count configuration.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, >=2.

Ports:
- clk_i  in  1  clock, rising edge.
- out_reg_shift_rst_i  in  1  asynchronous, active-high reset.
- in_data_i  in  W  signed partial sum from the upstream column shift register.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  block can accept a beat.
- cfg_ld_i  in  1  latch pass_count_i and out_count_i; honoured in IDLE only.
- pass_count_i  in  PASS_WIDTH  beats summed per result; 0 is treated as 1.
- out_count_i  in  CNT_WIDTH  results produced per run.
- start_i  in  1  begin a run; honoured in IDLE only.
- out_data_o  out  W  signed saturated result (FIFO head).
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  downstream accepts.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at the end of a run.
- overflow_o  out  1  sticky saturation flag.

Behaviour:
- Reset: state IDLE; accumulator, pass counter, result counter, FIFO pointers and config registers all 0. Outputs: in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, overflow_o=0. A reset asserted mid-run aborts the run immediately and discards FIFO contents.
- FSM states:
  - IDLE: cfg_ld_i loads the config. start_i clears the accumulator, both counters and overflow_o. If the stored out_count is 0, go to DRAIN; otherwise go to RUN. If cfg_ld_i and start_i are asserted in the same cycle, the start uses the newly loaded values.
  - RUN: in_ready_o = !fifo_full. Beat accepted when in_valid_i && in_ready_o.
  - DRAIN: in_ready_o=0. When the FIFO is empty, assert done_o for one cycle and go to IDLE.
- Accumulation:
  - Sign-extend in_data_i to A bits. On an accepted beat, sum = acc + in.
  - If pass_cnt == effective_pass-1: push sat(sum) into the FIFO, set acc=0, pass_cnt=0, and increment res_cnt. Otherwise acc=sum and pass_cnt increments.
  - When the pushed result is number out_count, go to DRAIN in the same edge.
- Saturation: clamp to [-2^(W-1), 2^(W-1)-1]. On a clamp, set overflow_o, which stays set until reset or the next accepted start_i. Accumulator overflow within the A bits is not checked.
- FIFO and output timing:
  - Registered FIFO. out_valid_o = !empty and out_data_o = head entry.
  - Pop on out_valid_o && out_ready_i.
  - Latency: a result is visible on out_data_o one cycle after its final beat is accepted.
  - Push and pop in the same cycle are both performed, with occupancy unchanged.
  - When the FIFO is full, in_ready_o=0. No push can occur while full, so no data is lost.
  - Pop when empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Config and start outside IDLE: start_i and cfg_ld_i are ignored; the current run is unaffected.
- in_valid_i outside RUN: ignored, with in_ready_o=0.

Optional Feature:
- Macro: OUT_COL_ACCUM_RELU_EN.
- Defined: adds input relu_en_i (1 bit, latched by cfg_ld_i). When the latched value is 1, negative saturated results are replaced by 0 before the FIFO push, and overflow_o is still computed on the pre-ReLU value.
- Undefined: the port is absent and results pass through unmodified.

Test Plan:
- Reset/idle: assert reset mid-RUN with 2 entries in the FIFO -> all outputs 0 next cycle; then start with no cfg_ld_i -> out_count=0, straight to DRAIN, done_o pulse, no output.
- Basic sum (W=16): pass=3, count=1, beats 0x0100, 0x0200, 0xFF00 -> out_data_o=0x0200 one cycle after the 3rd beat; done_o fires after the pop.
- Saturation: pass=2, beats 0x7000, 0x7000 -> 0x7FFF and overflow_o=1. Next run: beats 0x8000, 0x8000 -> 0x8000, and overflow_o is cleared by start then set again.
- Back-pressure: pass=1, count=6, out_ready_i=0 -> in_ready_o drops after 4 pushes. Release out_ready_i -> all 6 values emerge in order, unchanged.
- Simultaneous push/pop at full: FIFO full, pop and pass=1 beat in consecutive cycles -> occupancy never exceeds 4 and ordering is preserved.
- pass_count_i=0 with beat 0x0003 -> treated as 1, output 0x0003. With OUT_COL_ACCUM_RELU_EN defined and relu_en_i=1, beat 0xFFFD -> 0x0000.
